// File: rtl/l2_resp_pkg.sv
// l2_resp_pkg: shared types and constants for the L2 line responder
package l2_resp_pkg;
    localparam int OFFSET_BITS   = 6;
    localparam int L2_PADDR_BITS = 22;
    localparam int L2_LINE_BITS  = 512;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    typedef struct packed {
        logic [L2_PADDR_BITS-1:0] addr;
        logic [L2_LINE_BITS-1:0]  value;
        logic                     we;
    } line_req_t;
endpackage

// File: rtl/line_req_fifo.sv
// line_req_fifo: in-order request queue with registered count and full/empty flags
module line_req_fifo
    import l2_resp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      push_in,
    input  line_req_t data_in,
    input  logic      pop_in,
    output line_req_t data_out,
    output logic      full_out,
    output logic      empty_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    line_req_t     mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign full_out  = cnt_q == CW'(DEPTH);
    assign empty_out = cnt_q == '0;
    assign do_push   = push_in && !full_out;
    assign do_pop    = pop_in && !empty_out;
    assign data_out  = mem_q[rd_q];
    assign cnt_d     = cnt_q + CW'(do_push) - CW'(do_pop);
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_q] <= data_in;
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/l2_line_responder.sv
// l2_line_responder: queued, fixed-latency line store answering L1D line requests
// Optional write acknowledge beats when L2_RESP_WRITE_ACK_EN is defined.
module l2_line_responder
    import l2_resp_pkg::*;
#(
    parameter int PADDR_BITS  = 22,
    parameter int LINE_BITS   = 512,
    parameter int DEPTH       = 64,
    parameter int QUEUE_DEPTH = 4,
    parameter int LATENCY     = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  l1_valid_in,
    output logic                  l1_ready_out,
    input  logic [PADDR_BITS-1:0] l1_addr_in,
    input  logic [LINE_BITS-1:0]  l1_value_in,
    input  logic                  l1_we_in,
    output logic                  l1_valid_out,
    input  logic                  l1_ready_in,
    output logic [PADDR_BITS-1:0] l1_addr_out,
    output logic [LINE_BITS-1:0]  l1_value_out
);
`ifdef L2_RESP_WRITE_ACK_EN
    localparam logic WRITE_ACK = 1'b1;
`else
    localparam logic WRITE_ACK = 1'b0;
`endif
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q;
    line_req_t             req_q, head, req_in;
    logic                  full, empty, pop, access, respond;
    logic [PADDR_BITS-1:0] addr_q, line_addr;
    logic [LINE_BITS-1:0]  value_q;
    logic [LINE_BITS-1:0]  store [DEPTH];
    logic [IW-1:0]         idx;
    assign req_in       = '{addr: l1_addr_in, value: l1_value_in, we: l1_we_in};
    assign l1_ready_out = !full;
    assign l1_valid_out = state_q == RESP;
    assign l1_addr_out  = addr_q;
    assign l1_value_out = value_q;
    assign pop          = state_q == IDLE && !empty;
    assign access       = state_q == WAIT && cnt_q == CW'(1);
    assign respond      = !req_q.we || WRITE_ACK;
    assign idx          = req_q.addr[OFFSET_BITS +: IW];
    assign line_addr    = {req_q.addr[PADDR_BITS-1:OFFSET_BITS], OFFSET_BITS'(0)};
    line_req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push_in  (l1_valid_in),
        .data_in  (req_in),
        .pop_in   (pop),
        .data_out (head),
        .full_out (full),
        .empty_out(empty)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = empty ? IDLE : WAIT;
            WAIT:    state_d = !access ? WAIT : respond ? RESP : IDLE;
            RESP:    state_d = l1_ready_in ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    // The store has no reset so preloaded/written lines survive rst_in.
    always_ff @(posedge clk_in) begin
        if (access && req_q.we) store[idx] <= req_q.value;
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            addr_q  <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                req_q <= head;
                cnt_q <= CW'(LATENCY);
            end else if (state_q == WAIT && !access) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (access && respond) begin
                addr_q  <= line_addr;
                value_q <= req_q.we ? '0 : store[idx];
            end
        end
    end
endmodule
